// File: rtl/asymmetric_fifo_bidir.sv
// Asymmetric-width synchronous FIFO for narrowing, widening or equal widths.
// Storage is kept in units of U = min(WIDTH_IN, WIDTH_OUT) bits. Pointers are
// in units and carry a wrap bit. Data ordering is little-endian: the low unit
// of d is stored first, and the first stored unit lands in the low unit of q.
//
// Optional feature macro: ASYM_FIFO_FWFT_EN
//   defined   : first-word-fall-through; q shows the head word while !empty
//   undefined : q is registered and loads the head word on an accepted pop
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   push / d     write one WIDTH_IN word (ignored and flagged when full)
//   pop  / q     read one WIDTH_OUT word (ignored and flagged when empty)
//   full, empty  combinational status from the pointers
//   count        complete output words stored
//   space        complete input words that still fit
//   almost_empty count <= ALMOST_EMPTY_COUNT
//   almost_full  space <= ALMOST_FULL_COUNT
//   overflow     sticky, push attempted while full
//   underflow    sticky, pop attempted while empty
module asymmetric_fifo_bidir #(
  parameter int unsigned WIDTH_IN           = 64,
  parameter int unsigned WIDTH_OUT          = 8,
  parameter int unsigned DEPTH_IN           = 32,
  parameter int unsigned ALMOST_EMPTY_COUNT = 1,
  parameter int unsigned ALMOST_FULL_COUNT  = 1
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              push,
  input  logic                                              pop,
  input  logic [WIDTH_IN-1:0]                               d,
  output logic [WIDTH_OUT-1:0]                              q,
  output logic                                              full,
  output logic                                              empty,
  output logic [$clog2((DEPTH_IN*WIDTH_IN)/WIDTH_OUT):0]    count,
  output logic [$clog2(DEPTH_IN):0]                         space,
  output logic                                              almost_empty,
  output logic                                              almost_full,
  output logic                                              overflow,
  output logic                                              underflow
);

  localparam int unsigned U         = (WIDTH_IN < WIDTH_OUT) ? WIDTH_IN : WIDTH_OUT;
  localparam int unsigned IN_UNITS  = WIDTH_IN / U;
  localparam int unsigned OUT_UNITS = WIDTH_OUT / U;
  localparam int unsigned TOTAL     = DEPTH_IN * IN_UNITS;
  localparam int unsigned AW        = $clog2(TOTAL);
  localparam int unsigned PTR_W     = AW + 1;
  localparam int unsigned CNT_W     = $clog2((DEPTH_IN*WIDTH_IN)/WIDTH_OUT) + 1;
  localparam int unsigned SPC_W     = $clog2(DEPTH_IN) + 1;

  logic [U-1:0]         mem_q [TOTAL];
  logic [U-1:0]         mem_d [TOTAL];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;
  logic [PTR_W-1:0]     used;
  logic [PTR_W-1:0]     free_units;
  logic                 push_ok;
  logic                 pop_ok;
  logic [WIDTH_OUT-1:0] head;

  // Occupancy and status flags, all derived from the pointer difference
  always_comb begin
    used         = wr_ptr_q - rd_ptr_q;
    free_units   = PTR_W'(TOTAL) - used;
    full         = (free_units < PTR_W'(IN_UNITS));
    empty        = (used < PTR_W'(OUT_UNITS));
    count        = CNT_W'(used / PTR_W'(OUT_UNITS));
    space        = SPC_W'(free_units / PTR_W'(IN_UNITS));
    almost_empty = (32'(count) <= ALMOST_EMPTY_COUNT);
    almost_full  = (32'(space) <= ALMOST_FULL_COUNT);
  end

  // Head output word assembled from OUT_UNITS consecutive units; index wraps by width
  always_comb begin
    head = '0;
    for (int unsigned j = 0; j < OUT_UNITS; j++) begin
      head[j*U +: U] = mem_q[rd_ptr_q[AW-1:0] + AW'(j)];
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

`ifdef ASYM_FIFO_FWFT_EN
  // Head word falls through; zeroed while empty to keep q quiet
  assign q = empty ? '0 : head;
`else
  logic [WIDTH_OUT-1:0] q_q, q_d;
  assign q = q_q;
`endif

  // Next-state: acceptance uses pre-edge full/empty only
  always_comb begin
    push_ok     = push & ~full;
    pop_ok      = pop & ~empty;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q | (push & full);
    underflow_d = underflow_q | (pop & empty);
    mem_d       = mem_q;
`ifndef ASYM_FIFO_FWFT_EN
    q_d         = q_q;
`endif
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(IN_UNITS);
      for (int unsigned i = 0; i < IN_UNITS; i++) begin
        mem_d[wr_ptr_q[AW-1:0] + AW'(i)] = d[i*U +: U];
      end
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(OUT_UNITS);
`ifndef ASYM_FIFO_FWFT_EN
      q_d      = head;
`endif
    end
  end

  // Control state; storage is deliberately left out of reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
`ifndef ASYM_FIFO_FWFT_EN
      q_q         <= '0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
`ifndef ASYM_FIFO_FWFT_EN
      q_q         <= q_d;
`endif
    end
  end

  // Unit storage
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
